// File: rtl/spi_byte_port.sv
// Mode-0, MSB-first SPI slave byte front end: pin synchronisers, byte deserialiser and miso serialiser.
// Define SPI_FRAME_PULSE_EN to get frame_start/frame_end strobes on select assertion/deassertion.
module spi_byte_port #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       byte_received,
  output logic [7:0] byte_data_received,
  input  logic [7:0] byte_send,
  input  logic       send_latch,
  output logic       frame_start,
  output logic       frame_end
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [2:0] sck_s_q;
  logic [2:0] ss_s_q;
  logic [1:0] mosi_s_q;
  logic [0:0] state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_strobe_q, rx_strobe_d;

  logic       sck_rise, sck_fall, sel, sel_fall, sel_rise;
  logic [7:0] load_value;

  assign sck_rise   = (sck_s_q[2:1] == 2'b01);
  assign sck_fall   = (sck_s_q[2:1] == 2'b10);
  assign sel        = ~ss_s_q[1];
  assign sel_fall   = (ss_s_q[2:1] == 2'b10);
  assign sel_rise   = (ss_s_q[2:1] == 2'b01);
  assign load_value = send_latch ? byte_send : FILL_BYTE;

  // Select is resynchronised to 1 on reset so releasing reset never fakes an edge.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      sck_s_q  <= 3'b000;
      ss_s_q   <= 3'b111;
      mosi_s_q <= 2'b00;
    end else begin
      sck_s_q  <= {sck_s_q[1:0], sclk};
      ss_s_q   <= {ss_s_q[1:0], ss};
      mosi_s_q <= {mosi_s_q[0], mosi};
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_fall) begin
          state_d    = ACTIVE;
          bitcnt_d   = 3'd0;
          tx_shift_d = load_value;
        end
      end
      ACTIVE: begin
        // Select deassertion takes priority; any partial byte is dropped silently.
        if (sel_rise) begin
          state_d  = IDLE;
          bitcnt_d = 3'd0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s_q[1]};
            bitcnt_d   = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_d   = {rx_shift_q[6:0], mosi_s_q[1]};
              rx_strobe_d = 1'b1;
            end
          end
          if (sck_fall) begin
            if (bitcnt_q == 3'd0) begin
              tx_shift_d = load_value;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_strobe_q <= rx_strobe_d;
    end
  end

  assign miso               = sel ? tx_shift_q[7] : 1'bz;
  assign byte_received      = rx_strobe_q;
  assign byte_data_received = rx_data_q;

`ifdef SPI_FRAME_PULSE_EN
  logic frame_start_q, frame_end_q;

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      frame_start_q <= (state_q == IDLE) && sel_fall;
      frame_end_q   <= (state_q == ACTIVE) && sel_rise;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
`else
  assign frame_start = 1'b0;
  assign frame_end   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_port.sv
// Scoreboard bench for spi_byte_port: host-side SPI driver, arbiter offer model, strobe monitor.
module tb_spi_byte_port;
  logic       clock_50 = 1'b0;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       ss;
  wire        miso;
  logic       byte_received;
  logic [7:0] byte_data_received;
  logic [7:0] byte_send;
  logic       send_latch;
  logic       frame_start;
  logic       frame_end;

  spi_byte_port #(.FILL_BYTE(8'hFF)) dut (
    .clock_50          (clock_50),
    .reset             (reset),
    .sclk              (sclk),
    .mosi              (mosi),
    .ss                (ss),
    .miso              (miso),
    .byte_received     (byte_received),
    .byte_data_received(byte_data_received),
    .byte_send         (byte_send),
    .send_latch        (send_latch),
    .frame_start       (frame_start),
    .frame_end         (frame_end)
  );

  always #10 clock_50 = ~clock_50;

  int checks = 0;
  int fails  = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  int exp_start = 0;
  int exp_end   = 0;
  int rx_cnt = 0;
  int exp_rx = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every byte_received strobe is matched against the oldest byte the host completed.
  initial begin
    logic prev_strobe;
    logic [7:0] exp;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clock_50);
      if (reset) begin
        if (byte_received) begin
          rx_cnt++;
          if (prev_strobe) check("strobe_back_to_back", 1, 0);
          if (rx_q.size() == 0) begin
            check("unexpected_strobe", int'(byte_data_received), -1);
          end else begin
            exp = rx_q.pop_front();
            check("rx_byte", int'(byte_data_received), int'(exp));
            $display("rx byte 0x%02h (expected 0x%02h)", byte_data_received, exp);
          end
        end
        prev_strobe = byte_received;
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
      end else begin
        prev_strobe = 1'b0;
      end
    end
  end

  task automatic frame_begin();
    ss = 1'b0;
    exp_start++;
    tx_q.delete();
    tx_q.push_back(send_latch ? byte_send : 8'hFF);
    #200;
  endtask

  task automatic frame_finish();
    #125;
    ss = 1'b1;
    exp_end++;
    #200;
  endtask

  // Host shifts nbits of val; the arbiter may change its offer mid-byte (after bit 3).
  task automatic spi_bits(input logic [7:0] val, input int nbits, input bit new_offer,
                          input bit latch, input logic [7:0] bs);
    logic [7:0] got;
    logic [7:0] exp_tx;
    got = 8'h00;
    if (nbits == 8) begin
      rx_q.push_back(val);
      exp_rx++;
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = val[7-i];
      #125;
      got = {got[6:0], miso};
      sclk = 1'b1;
      if (i == 3 && new_offer) begin
        send_latch = latch;
        byte_send  = bs;
      end
      #125;
      sclk = 1'b0;
    end
    if (nbits == 8) begin
      exp_tx = tx_q.pop_front();
      check("miso_byte", int'(got), int'(exp_tx));
      $display("tx byte 0x%02h on miso (expected 0x%02h), mosi 0x%02h", got, exp_tx, val);
      tx_q.push_back(send_latch ? byte_send : 8'hFF);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    send_latch = 1'b0; byte_send = 8'h00;
    #105;
    reset = 1'b1;
    repeat (10) @(negedge clock_50);
    check("reset_data", int'(byte_data_received), 0);
    check("reset_strobe", int'(byte_received), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_frame_end", int'(frame_end), 0);

    frame_begin();
    spi_bits(8'hA5, 8, 1'b0, 1'b0, 8'h00);
    frame_finish();

    send_latch = 1'b0;
    frame_begin();
    spi_bits(8'h11, 8, 1'b1, 1'b1, 8'h3C);
    spi_bits(8'h22, 8, 1'b1, 1'b0, 8'h00);
    frame_finish();

    frame_begin();
    spi_bits(8'hC3, 5, 1'b0, 1'b0, 8'h00);
    frame_finish();
    frame_begin();
    spi_bits(8'h81, 8, 1'b0, 1'b0, 8'h00);
    frame_finish();

    frame_begin();
    spi_bits(8'h01, 8, 1'b1, 1'b1, 8'h96);
    spi_bits(8'h12, 8, 1'b1, 1'b1, 8'h4B);
    spi_bits(8'h34, 8, 1'b1, 1'b0, 8'h00);
    frame_finish();

    // Reset in the middle of a byte: the frame is abandoned without an end strobe.
    frame_begin();
    spi_bits(8'hE7, 4, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    #1;
    check("midreset_data", int'(byte_data_received), 0);
    check("midreset_strobe", int'(byte_received), 0);
    sclk = 1'b0; ss = 1'b1;
    #100;
    reset = 1'b1;
    #200;
    frame_begin();
    spi_bits(8'h5A, 8, 1'b0, 1'b0, 8'h00);
    frame_finish();

    for (int f = 0; f < 12; f++) begin
      int nbytes;
      nbytes = int'($urandom_range(1, 3));
      send_latch = 1'($urandom_range(0, 1));
      byte_send  = 8'($urandom);
      frame_begin();
      for (int b = 0; b < nbytes; b++) begin
        int nb;
        nb = (b == nbytes - 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
        spi_bits(8'($urandom), nb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      frame_finish();
    end

    repeat (20) @(negedge clock_50);
    check("rx_queue_empty", rx_q.size(), 0);
    check("rx_strobe_count", rx_cnt, exp_rx);
`ifdef SPI_FRAME_PULSE_EN
    check("frame_start_count", fs_cnt, exp_start);
    check("frame_end_count", fe_cnt, exp_end);
`else
    check("frame_start_count", fs_cnt, 0);
    check("frame_end_count", fe_cnt, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
